// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO between fetch and decode.
// Holds {PC, instruction} pairs, presents the oldest to decode with PC+4,
// and empties on a branch/jump redirect (flush).
// Optional macro FETCH_QUEUE_BYPASS_EN: on an empty queue, forward the
// incoming pair straight to the output in the same cycle.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_pc4,
  output logic [31:0]      out_instr,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] CntFull = (PTR_W + 1)'(DEPTH);

  logic [31:0]      r_pc    [DEPTH];
  logic [31:0]      r_instr [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  // Handshake decode; a bypassed pair that decode takes is neither stored nor popped.
  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == CntFull);
`ifdef FETCH_QUEUE_BYPASS_EN
    w_bypass = w_empty && in_valid && !flush;
`else
    w_bypass = 1'b0;
`endif
    in_ready  = !w_full;
    out_valid = !w_empty || w_bypass;
    w_push    = in_valid && in_ready && !(w_bypass && out_ready);
    w_pop     = out_valid && out_ready && !w_bypass;
  end

  // Head read (or bypass forward) and link address.
  always_comb begin
    if (w_bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end else begin
      out_pc    = r_pc[r_rd_ptr];
      out_instr = r_instr[r_rd_ptr];
    end
    out_pc4 = out_pc + 32'd4;
    count   = r_count;
  end

  // Pointers and occupancy; flush overrides any same-cycle push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Entry storage; contents survive flush since pointers already hide them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
    end else if (w_push && !flush) begin
      r_pc[r_wr_ptr]    <= in_pc;
      r_instr[r_wr_ptr] <= in_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_pc4   (out_pc4),
    .out_instr (out_instr),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs settle 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = ins;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_pc4", out_pc4, 4);
    check("rst_out_instr", out_instr, 0);
    rst_n = 1'b1;
    tick();
    check("idle_count", 32'(count), 0);

    // Two pushes with decode stalled, then one pop.
    push(32'h0, 32'h2008_0005);
    push(32'h4, 32'h2109_0001);
    check("two_count", 32'(count), 2);
    check("two_pc", out_pc, 32'h0);
    check("two_pc4", out_pc4, 32'h4);
    check("two_instr", out_instr, 32'h2008_0005);
    check("two_valid", 32'(out_valid), 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("pop1_pc", out_pc, 32'h4);
    check("pop1_instr", out_instr, 32'h2109_0001);
    check("pop1_count", 32'(count), 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("pop2_count", 32'(count), 0);

    // Fill to DEPTH, refused fifth push, drain in order.
    for (int i = 0; i < 4; i++) push(32'h8 + 32'(4 * i), 32'hA000_0000 + 32'(i));
    check("full_count", 32'(count), 4);
    check("full_in_ready", 32'(in_ready), 0);
    push(32'h18, 32'hDEAD_BEEF);
    check("full_refused_count", 32'(count), 4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", out_pc, 32'h8 + 32'(4 * i));
      check("drain_instr", out_instr, 32'hA000_0000 + 32'(i));
      tick();
    end
    out_ready = 1'b0;
    check("drain_valid", 32'(out_valid), 0);
    check("drain_count", 32'(count), 0);

    // Steady state at count=2 with push and pop every cycle.
    push(32'h100, 32'h1);
    push(32'h104, 32'h1);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_pc = 32'h108 + 32'(4 * k);
      #1;
      check("steady_pc", out_pc, 32'h100 + 32'(4 * k));
      check("steady_count", 32'(count), 2);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("steady_end_count", 32'(count), 2);
    check("steady_end_pc", out_pc, 32'h128);

    // Flush at count=3 with concurrent push and pop.
    push(32'h130, 32'h2);
    check("preflush_count", 32'(count), 3);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h320; in_instr = 32'h3; out_ready = 1'b1;
    #1;
    check("flush_cycle_in_ready", 32'(in_ready), 1);
    check("flush_cycle_out_valid", 32'(out_valid), 1);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("postflush_count", 32'(count), 0);
    check("postflush_valid", 32'(out_valid), 0);
    push(32'h320, 32'h3);
    check("refill_pc", out_pc, 32'h320);
    check("refill_count", 32'(count), 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // PC+4 wraps at the top of the address space.
    push(32'hFFFF_FFFC, 32'h4);
    check("wrap_pc4", out_pc4, 32'h0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("wrap_drained", 32'(count), 0);

    // Asynchronous reset mid-cycle with count=3.
    push(32'h400, 32'h5);
    push(32'h404, 32'h6);
    push(32'h408, 32'h7);
    check("prereset_count", 32'(count), 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_count", 32'(count), 0);
    check("async_valid", 32'(out_valid), 0);
    check("async_pc", out_pc, 0);
    #1 rst_n = 1'b1;
    push(32'h500, 32'h8);
    check("after_reset_pc", out_pc, 32'h500);
    check("after_reset_count", 32'(count), 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Empty queue with a pair offered and decode ready.
    in_valid = 1'b1; in_pc = 32'h40; in_instr = 32'h9; out_ready = 1'b1;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check("bypass_valid", 32'(out_valid), 1);
    check("bypass_pc", out_pc, 32'h40);
    check("bypass_pc4", out_pc4, 32'h44);
    tick();
    check("bypass_count", 32'(count), 0);
`else
    check("nobypass_valid", 32'(out_valid), 0);
    out_ready = 1'b0;
    tick();
    check("nobypass_count", 32'(count), 1);
    check("nobypass_pc", out_pc, 32'h40);
`endif
    in_valid = 1'b0; out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
